hazard_ctrl_unit: RTL

//  Parametrised pipeline hazard controller for the 5-stage RV32 core. Adds load-use stall and

---
 rtl/hazard_ctrl_unit_pkg.sv | 25 ++
 rtl/hazard_ctrl_unit_if.sv | 48 ++++
 rtl/hazard_ctrl_unit_perf_counter_sat.sv | 34 +++
 rtl/hazard_ctrl_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline types for the RV32 hazard controller.
//   hz_state_t : multiply-stall FSM states
//   hz_ctrl_t  : bundle of the pipeline-register control outputs
//   REG_X0     : architectural zero register index
package riscv_pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int REG_X0         = 0;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_fd;
    logic stall_de;
    logic flush_fd;
    logic flush_de;
    logic bubble_em;
    logic mul_busy;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-controller signal bundle between the pipeline and the hazard unit.
//   master : pipeline side, drives decode/execute fields, receives controls/counters
//   slave  : hazard unit side
interface hazard_ctrl_if
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write_en;
  logic                  ex_dmem_read_en;
  logic                  ex_mul_en;
  logic                  ex_redirect;
  logic                  perf_clr;

  logic                  stall_f;
  logic                  stall_fd;
  logic                  stall_de;
  logic                  flush_fd;
  logic                  flush_de;
  logic                  bubble_em;
  logic                  mul_busy;
  logic [CNT_W-1:0]      cnt_cycles;
  logic [CNT_W-1:0]      cnt_stalls;
  logic [CNT_W-1:0]      cnt_flushes;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_reg_write_en, ex_dmem_read_en, ex_mul_en,
           ex_redirect, perf_clr,
    input  stall_f, stall_fd, stall_de, flush_fd, flush_de, bubble_em,
           mul_busy, cnt_cycles, cnt_stalls, cnt_flushes
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_reg_write_en, ex_dmem_read_en, ex_mul_en,
           ex_redirect, perf_clr,
    output stall_f, stall_fd, stall_de, flush_fd, flush_de, bubble_em,
           mul_busy, cnt_cycles, cnt_stalls, cnt_flushes
  );

endinterface

// File: rtl/hazard_ctrl_unit_perf_counter_sat.sv
// Saturating performance counter.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear, wins over inc
//   inc        : count this cycle
//   count      : current value, sticks at all-ones
module perf_counter_sat
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core.
//   clk, reset : clock, asynchronous active-high reset
//   hz (slave) : decode/execute fields in; stall/flush/bubble controls and
//                saturating cycle/stall/flush counters out
// Priority in IDLE: redirect > multiply start > load-use. A multiply freezes
// the pipeline for MUL_LAT-1 cycles: the start cycle plus MUL_LAT-2 BUSY cycles.
module hazard_ctrl_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MUL_LAT    = 3,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  hazard_ctrl_if.slave hz
);

  localparam int MC_W       = $clog2(MUL_LAT + 1);
  localparam bit MUL_STALLS = (MUL_LAT > 1);
  localparam bit HAS_BUSY   = (MUL_LAT > 2);
  // BUSY lasts MUL_LAT-2 cycles; the counter holds BUSY cycles left after the current one.
  localparam int CNT_LOAD   = (MUL_LAT > 3) ? (MUL_LAT - 3) : 0;

  hz_state_t       r_state, w_state_nxt;
  logic [MC_W-1:0] r_mul_cnt, w_mul_cnt_nxt;
  logic            r_done, w_done_nxt;
  logic            w_load_use;
  logic            w_mul_start;
  hz_ctrl_t        w_ctrl, w_ctrl_o;

  // A load and a multiply both set is illegal; it is handled as a multiply.
  assign w_load_use = hz.ex_dmem_read_en && hz.ex_reg_write_en && !hz.ex_mul_en &&
                      (hz.ex_rd_addr != REG_ADDR_W'(REG_X0)) &&
                      ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                       (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

  // r_done masks the finished multiply still sitting in EX on the release cycle.
  assign w_mul_start = MUL_STALLS && hz.ex_mul_en && !r_done;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    w_done_nxt    = 1'b0;
    w_ctrl        = '0;
    unique case (r_state)
      HZ_IDLE: begin
        if (hz.ex_redirect) begin
          w_ctrl.flush_fd = 1'b1;
          w_ctrl.flush_de = 1'b1;
        end else if (w_mul_start) begin
          w_ctrl.stall_f   = 1'b1;
          w_ctrl.stall_fd  = 1'b1;
          w_ctrl.stall_de  = 1'b1;
          w_ctrl.bubble_em = 1'b1;
          if (HAS_BUSY) begin
            w_state_nxt   = HZ_BUSY;
            w_mul_cnt_nxt = MC_W'(CNT_LOAD);
          end else begin
            w_done_nxt = 1'b1;
          end
        end else if (w_load_use) begin
          w_ctrl.stall_f  = 1'b1;
          w_ctrl.stall_fd = 1'b1;
          w_ctrl.flush_de = 1'b1;
        end
      end
      HZ_BUSY: begin
        w_ctrl.stall_f   = 1'b1;
        w_ctrl.stall_fd  = 1'b1;
        w_ctrl.stall_de  = 1'b1;
        w_ctrl.bubble_em = 1'b1;
        w_ctrl.mul_busy  = 1'b1;
        if (r_mul_cnt == '0) begin
          w_state_nxt = HZ_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_mul_cnt_nxt = r_mul_cnt - 1'b1;
        end
      end
      default: w_state_nxt = HZ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= HZ_IDLE;
      r_mul_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Controls drop asynchronously with reset, even mid-multiply.
  assign w_ctrl_o     = reset ? hz_ctrl_t'('0) : w_ctrl;
  assign hz.stall_f   = w_ctrl_o.stall_f;
  assign hz.stall_fd  = w_ctrl_o.stall_fd;
  assign hz.stall_de  = w_ctrl_o.stall_de;
  assign hz.flush_fd  = w_ctrl_o.flush_fd;
  assign hz.flush_de  = w_ctrl_o.flush_de;
  assign hz.bubble_em = w_ctrl_o.bubble_em;
  assign hz.mul_busy  = w_ctrl_o.mul_busy;

  perf_counter_sat #(.CNT_W(CNT_W)) u_cnt_cycles (
    .clk(clk), .reset(reset), .clr(hz.perf_clr), .inc(1'b1), .count(hz.cnt_cycles)
  );

  perf_counter_sat #(.CNT_W(CNT_W)) u_cnt_stalls (
    .clk(clk), .reset(reset), .clr(hz.perf_clr), .inc(w_ctrl_o.stall_f), .count(hz.cnt_stalls)
  );

  perf_counter_sat #(.CNT_W(CNT_W)) u_cnt_flushes (
    .clk(clk), .reset(reset), .clr(hz.perf_clr), .inc(w_ctrl_o.flush_fd), .count(hz.cnt_flushes)
  );

endmodule
